fma16_sched: RTL and testbench

Round-robin issue scheduler that shares one pipelined fma16 datapath (multiplier, alignment with `fmaalign`, adder, normalize/round) among `NREQ` requesters. The block accepts one operation per cycle, drives the datapath operand and control lines from registers, and tracks in-flight operations with a tag pipeline matched to the datapath latency. Each completed result is held in a per-requester result register until acknowledged. It sits between the requesters and the fma16 datapath. It owns all sequencing, and the datapath remains purely feed-forward.

---
 rtl/fma16_sched.sv | 154 +++++++++++++++
 tb/tb_fma16_sched.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fma16_sched.sv
// ============================================================================
// fma16_sched : round-robin issue scheduler in front of a shared, pipelined
//               fma16 datapath, with per-requester result holding registers.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fma16_sched #(
  parameter int NREQ = 4,
  parameter int LAT  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_x,
  input  logic [16*NREQ-1:0]   req_y,
  input  logic [16*NREQ-1:0]   req_z,
  input  logic [4*NREQ-1:0]    req_ctrl,
  output logic                 fma_valid,
  output logic [15:0]          fma_x,
  output logic [15:0]          fma_y,
  output logic [15:0]          fma_z,
  output logic [3:0]           fma_ctrl,
  input  logic [15:0]          fma_result,
  input  logic [3:0]           fma_flags,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [16*NREQ-1:0]   rsp_result,
  output logic [4*NREQ-1:0]    rsp_flags,
  input  logic [NREQ-1:0]      rsp_ack
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   r_ptr;
  logic [NREQ-1:0] r_busy;
  logic            r_fma_valid;
  logic [15:0]     r_fma_x;
  logic [15:0]     r_fma_y;
  logic [15:0]     r_fma_z;
  logic [3:0]      r_fma_ctrl;
  logic [NREQ-1:0] r_rsp_valid;

  // Stage 0 is the issue cycle; stage LAT is the cycle fma_result is valid.
  logic            r_tag_v  [0:LAT];
  logic [PW-1:0]   r_tag_id [0:LAT];

  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_ack;
  logic [NREQ-1:0] w_cap;
  logic            w_found;
  logic            w_accept;
  logic [PW-1:0]   w_gnt_idx;
  int              w_scan;

  assign w_elig   = req_valid & ~r_busy;
  assign w_ack    = rsp_ack & r_rsp_valid;
  assign w_accept = |req_ready;

  // Scan from the pointer, wrapping modulo NREQ; first eligible wins.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_scan    = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = int'(r_ptr) + k;
      if (w_scan >= NREQ) begin
        w_scan = w_scan - NREQ;
      end
      if (!w_found && w_elig[w_scan]) begin
        w_found   = 1'b1;
        w_gnt_idx = PW'(w_scan);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_found && !reset) begin
      req_ready[w_gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    w_cap = '0;
    if (r_tag_v[LAT]) begin
      w_cap[r_tag_id[LAT]] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr       <= '0;
      r_busy      <= '0;
      r_fma_valid <= 1'b0;
      r_fma_x     <= '0;
      r_fma_y     <= '0;
      r_fma_z     <= '0;
      r_fma_ctrl  <= '0;
      r_rsp_valid <= '0;
      for (int s = 0; s <= LAT; s++) begin
        r_tag_v[s]  <= 1'b0;
        r_tag_id[s] <= '0;
      end
    end else begin
      r_fma_valid <= w_accept;
      if (w_accept) begin
        r_fma_x    <= req_x[16*w_gnt_idx +: 16];
        r_fma_y    <= req_y[16*w_gnt_idx +: 16];
        r_fma_z    <= req_z[16*w_gnt_idx +: 16];
        r_fma_ctrl <= req_ctrl[4*w_gnt_idx +: 4];
        r_ptr      <= (w_gnt_idx == PW'(NREQ-1)) ? '0 : w_gnt_idx + PW'(1);
      end
      // An ack can only target a busy requester, never the one being granted.
      r_busy      <= (r_busy & ~w_ack) | req_ready;
      r_rsp_valid <= (r_rsp_valid & ~w_ack) | w_cap;
      r_tag_v[0]  <= w_accept;
      r_tag_id[0] <= w_gnt_idx;
      for (int s = 1; s <= LAT; s++) begin
        r_tag_v[s]  <= r_tag_v[s-1];
        r_tag_id[s] <= r_tag_id[s-1];
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_rsp
    logic [15:0] r_res;
    logic [3:0]  r_flg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_res <= '0;
        r_flg <= '0;
      end else if (w_cap[g]) begin
        r_res <= fma_result;
        r_flg <= fma_flags;
      end
    end

    assign rsp_result[16*g +: 16] = r_res;
    assign rsp_flags[4*g +: 4]    = r_flg;
  end

  assign fma_valid = r_fma_valid;
  assign fma_x     = r_fma_x;
  assign fma_y     = r_fma_y;
  assign fma_z     = r_fma_z;
  assign fma_ctrl  = r_fma_ctrl;
  assign rsp_valid = r_rsp_valid;

endmodule

`default_nettype wire

// File: tb/tb_fma16_sched.sv
// ============================================================================
// tb_fma16_sched : directed, table-driven bench for fma16_sched with an fp16
//                  datapath stand-in of fixed latency.  Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fma16_sched;
  localparam int NREQ = 4;
  localparam int LAT  = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [16*NREQ-1:0]   req_x, req_y, req_z;
  logic [4*NREQ-1:0]    req_ctrl;
  logic                 fma_valid;
  logic [15:0]          fma_x, fma_y, fma_z;
  logic [3:0]           fma_ctrl;
  logic [15:0]          fma_result;
  logic [3:0]           fma_flags;
  logic [NREQ-1:0]      rsp_valid;
  logic [16*NREQ-1:0]   rsp_result;
  logic [4*NREQ-1:0]    rsp_flags;
  logic [NREQ-1:0]      rsp_ack;

  int n_checks = 0;
  int n_errors = 0;

  fma16_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_ctrl(req_ctrl),
    .fma_valid(fma_valid), .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z),
    .fma_ctrl(fma_ctrl), .fma_result(fma_result), .fma_flags(fma_flags),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .rsp_ack(rsp_ack)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: known fp16 cases by table, otherwise an xor signature.
  function automatic logic [19:0] dp_model(input logic [15:0] x, input logic [15:0] y,
                                           input logic [15:0] z, input logic [3:0] c);
    logic [19:0] r;
    case ({x, y, z, c})
      {16'h4000, 16'h4200, 16'h3C00, 4'b1100}: r = {4'h0, 16'h4700};
      {16'h3C00, 16'h3C00, 16'h0000, 4'b1100}: r = {4'h0, 16'h3C00};
      {16'h4400, 16'h3800, 16'h0000, 4'b1100}: r = {4'h0, 16'h4000};
      {16'h4000, 16'h4000, 16'h3C00, 4'b1101}: r = {4'h0, 16'h4200};
      {16'h7BFF, 16'h7BFF, 16'h0000, 4'b1100}: r = {4'h5, 16'h7C00};
      {16'h0000, 16'h0000, 16'h0000, 4'b1000}: r = {4'h0, 16'h0000};
      default:                                 r = {c, x ^ y ^ z};
    endcase
    return r;
  endfunction

  logic [19:0] mp [LAT];
  always @(posedge clk) begin
    mp[0] <= fma_valid ? dp_model(fma_x, fma_y, fma_z, fma_ctrl) : 20'hFBAD0;
    for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
  end
  assign fma_result = mp[LAT-1][15:0];
  assign fma_flags  = mp[LAT-1][19:16];

  typedef struct {
    int          id;
    logic [15:0] x, y, z;
    logic [3:0]  ctrl;
    logic [15:0] res;
    logic [3:0]  flg;
  } vec_t;

  vec_t       vecs [6];
  logic [3:0] fair_exp [14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_ops(input int id, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] z, input logic [3:0] c);
    req_x[16*id +: 16]  = x;
    req_y[16*id +: 16]  = y;
    req_z[16*id +: 16]  = z;
    req_ctrl[4*id +: 4] = c;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = '0; rsp_ack = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [NREQ-1:0] oh;
    int n;
    oh = '0;
    oh[v.id] = 1'b1;
    @(negedge clk);
    set_ops(v.id, v.x, v.y, v.z, v.ctrl);
    req_valid = oh;
    #1 check("vec_ready", req_ready, oh);
    @(negedge clk);
    req_valid = '0;
    check("vec_fma_valid", fma_valid, 1);
    check("vec_fma_x", fma_x, v.x);
    check("vec_fma_y", fma_y, v.y);
    check("vec_fma_z", fma_z, v.z);
    check("vec_fma_ctrl", fma_ctrl, v.ctrl);
    n = 1;
    while (!rsp_valid[v.id] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("vec_latency", n, LAT + 2);
    check("vec_rsp_valid", rsp_valid, oh);
    check("vec_result", rsp_result[16*v.id +: 16], v.res);
    check("vec_flags", rsp_flags[4*v.id +: 4], v.flg);
    rsp_ack = oh;
    @(negedge clk);
    rsp_ack = '0;
    check("vec_ack_clear", rsp_valid, 0);
  endtask

  initial begin
    logic [19:0]     r;
    int              cnt [NREQ];
    int              n;
    logic [NREQ-1:0] seen;

    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0]     r;
    int              cnt [NREQ];
    int              n;
    logic [NREQ-1:0] seen;

    vecs[0] = '{0, 16'h4000, 16'h4200, 16'h3C00, 4'b1100, 16'h4700, 4'h0};
    vecs[1] = '{1, 16'h3C00, 16'h3C00, 16'h0000, 4'b1100, 16'h3C00, 4'h0};
    vecs[2] = '{3, 16'h4400, 16'h3800, 16'h0000, 4'b1100, 16'h4000, 4'h0};
    vecs[3] = '{2, 16'h4000, 16'h4000, 16'h3C00, 4'b1101, 16'h4200, 4'h0};
    vecs[4] = '{1, 16'h7BFF, 16'h7BFF, 16'h0000, 4'b1100, 16'h7C00, 4'h5};
    vecs[5] = '{2, 16'h0000, 16'h0000, 16'h0000, 4'b1000, 16'h0000, 4'h0};
    fair_exp = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h1,
                 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h1, 4'h2};

    reset = 1'b1; req_valid = '1; rsp_ack = '0;
    req_x = '0; req_y = '0; req_z = '0; req_ctrl = '0;
    #1 check("reset_ready", req_ready, 0);
    @(negedge clk);
    check("reset_fma_valid", fma_valid, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_fma_x", fma_x, 0);
    check("reset_fma_ctrl", fma_ctrl, 0);
    check("reset_rsp_result", rsp_result[31:0], 0);
    req_valid = '0;
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Fairness: everyone requests continuously and acks on arrival.
    do_reset();
    for (int i = 0; i < NREQ; i++)
      set_ops(i, 16'h1000 | 16'(i), 16'h0200 | 16'(i << 4), 16'h0030, 4'(i));
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      req_valid = '1;
      rsp_ack = rsp_valid;
      #1 check("fair_grant", req_ready, fair_exp[c]);
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_ack[i]) begin
          r = dp_model(req_x[16*i +: 16], req_y[16*i +: 16], req_z[16*i +: 16], req_ctrl[4*i +: 4]);
          check("fair_result", rsp_result[16*i +: 16], r[15:0]);
          check("fair_flags", rsp_flags[4*i +: 4], r[19:16]);
        end
      end
    end

    // Outstanding limit: requester 2 never acks.
    do_reset();
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      req_valid = '1;
      rsp_ack = rsp_valid & 4'b1011;
      #1;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) cnt[i]++;
    end
    check("hold_cnt0", cnt[0], 5);
    check("hold_cnt1", cnt[1], 5);
    check("hold_cnt2", cnt[2], 1);
    check("hold_cnt3", cnt[3], 5);
    check("hold_rsp_valid2", rsp_valid[2], 1);
    r = dp_model(req_x[47:32], req_y[47:32], req_z[47:32], req_ctrl[11:8]);
    check("hold_result2", rsp_result[47:32], r[15:0]);

    // Back-to-back: ptr=2 after one op from requester 1, then 1 and 3 together.
    do_reset();
    run_vec(vecs[1]);
    @(negedge clk);
    set_ops(1, 16'h3C00, 16'h3C00, 16'h0000, 4'b1100);
    set_ops(3, 16'h4400, 16'h3800, 16'h0000, 4'b1100);
    req_valid = 4'b1010;
    #1 check("b2b_first", req_ready, 4'b1000);
    @(negedge clk);
    #1 check("b2b_second", req_ready, 4'b0010);
    check("b2b_fma_x3", fma_x, 16'h4400);
    check("b2b_fma_y3", fma_y, 16'h3800);
    @(negedge clk);
    req_valid = '0;
    #1 check("b2b_fma_x1", fma_x, 16'h3C00);
    n = 0;
    while (rsp_valid != 4'b1010 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b_rsp_valid", rsp_valid, 4'b1010);
    check("b2b_result1", rsp_result[31:16], 16'h3C00);
    check("b2b_result3", rsp_result[63:48], 16'h4000);
    rsp_ack = 4'b1010;
    @(negedge clk);
    rsp_ack = '0;
    check("b2b_ack_clear", rsp_valid, 0);

    // Ack of 0, accept of 1 and capture for 2 on one edge.
    do_reset();
    set_ops(0, 16'h4000, 16'h4200, 16'h3C00, 4'b1100);
    set_ops(1, 16'h1234, 16'h0F0F, 16'h00FF, 4'b0110);
    set_ops(2, 16'h7BFF, 16'h7BFF, 16'h0000, 4'b1100);
    @(negedge clk);
    req_valid = 4'b0001;
    #1 check("sim_grant0", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = 4'b0100;
    #1 check("sim_grant2", req_ready, 4'b0100);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid = '0;
    end
    @(negedge clk);
    req_valid = 4'b0010;
    rsp_ack = 4'b0001;
    #1 check("sim_pre_rsp_valid", rsp_valid, 4'b0001);
    check("sim_grant1", req_ready, 4'b0010);
    check("sim_result0", rsp_result[15:0], 16'h4700);
    @(negedge clk);
    req_valid = 4'b0001;
    rsp_ack = '0;
    #1 check("sim_post_rsp_valid", rsp_valid, 4'b0100);
    check("sim_issue1_valid", fma_valid, 1);
    check("sim_issue1_x", fma_x, 16'h1234);
    check("sim_result2", rsp_result[47:32], 16'h7C00);
    check("sim_flags2", rsp_flags[11:8], 4'h5);
    check("sim_regrant0", req_ready, 4'b0001);

    // Reset while two ops are in flight.
    do_reset();
    @(negedge clk);
    req_valid = 4'b0001;
    #1 check("mid_grant0", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = 4'b0010;
    #1 check("mid_grant1", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    reset = 1'b1;
    #1 check("mid_rst_fma_valid", fma_valid, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    check("mid_no_capture", seen, 0);
    @(negedge clk);
    req_valid = 4'b1101;
    #1 check("mid_post_grant", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
